// File: rtl/alu_result_fifo.sv
// In-order FIFO buffering ALU results and flags for writeback, with sticky
// overflow/carry status for ADD/SUB that holds until software clears it.
module alu_result_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 in_opcode,
  input  logic [WIDTH-1:0]           in_result,
  input  logic [3:0]                 in_flags,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [3:0]                 out_opcode,
  output logic [WIDTH-1:0]           out_result,
  output logic [3:0]                 out_flags,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [1:0]                 sticky_flags,
  input  logic                       sticky_clear
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned EW = WIDTH + 8;

  localparam logic [3:0] OP_ADD = 4'b0110;
  localparam logic [3:0] OP_SUB = 4'b0111;

  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          full;
  logic          push;
  logic          pop;
  logic          arith;
  logic          sticky_ov;
  logic          sticky_cy;

  assign full      = (cnt == CW'(DEPTH));
  assign in_ready  = ~reset & ~full;
  assign out_valid = (cnt != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign arith     = (in_opcode == OP_ADD) || (in_opcode == OP_SUB);

  // Storage is never reset; a stale head is hidden by the out_valid mask.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_opcode, in_result, in_flags};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // A qualifying push in the same cycle as sticky_clear leaves its bit set.
  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_ov <= 1'b0;
      sticky_cy <= 1'b0;
    end else begin
      if (sticky_clear) begin
        sticky_ov <= 1'b0;
        sticky_cy <= 1'b0;
      end
      if (push && arith && in_flags[3]) begin
        sticky_ov <= 1'b1;
      end
      if (push && arith && in_flags[2]) begin
        sticky_cy <= 1'b1;
      end
    end
  end

  assign head         = mem[rd_ptr];
  assign out_opcode   = out_valid ? head[EW-1 -: 4]    : '0;
  assign out_result   = out_valid ? head[WIDTH+3 : 4]  : '0;
  assign out_flags    = out_valid ? head[3:0]          : '0;
  assign count        = cnt;
  assign sticky_flags = {sticky_ov, sticky_cy};

endmodule

// File: tb/tb_alu_result_fifo.sv
// Self-checking bench for alu_result_fifo: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_alu_result_fifo;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       in_opcode = '0;
  logic [WIDTH-1:0] in_result = '0;
  logic [3:0]       in_flags = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [3:0]       out_opcode;
  logic [WIDTH-1:0] out_result;
  logic [3:0]       out_flags;
  logic [CW-1:0]    count;
  logic [1:0]       sticky_flags;
  logic             sticky_clear = 1'b0;

  int checks = 0;
  int failures = 0;

  // Reference model: entries as {opcode, result, flags}, plus sticky bits.
  logic [WIDTH+7:0] q[$];
  logic             m_ov = 1'b0;
  logic             m_cy = 1'b0;

  alu_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_opcode    (in_opcode),
    .in_result    (in_result),
    .in_flags     (in_flags),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_opcode   (out_opcode),
    .out_result   (out_result),
    .out_flags    (out_flags),
    .count        (count),
    .sticky_flags (sticky_flags),
    .sticky_clear (sticky_clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    logic [WIDTH+7:0] h;
    n = q.size();
    h = (n != 0) ? q[0] : '0;
    chk({tag, ".count"},     64'(count),        64'(n));
    chk({tag, ".out_valid"}, 64'(out_valid),    64'(n != 0));
    chk({tag, ".in_ready"},  64'(in_ready),     64'(n != DEPTH));
    chk({tag, ".opcode"},    64'(out_opcode),   64'(h[WIDTH+7 -: 4]));
    chk({tag, ".result"},    64'(out_result),   64'(h[WIDTH+3 : 4]));
    chk({tag, ".flags"},     64'(out_flags),    64'(h[3:0]));
    chk({tag, ".sticky"},    64'(sticky_flags), 64'({m_ov, m_cy}));
  endtask

  // One clock: drive inputs, advance model by the handshake rules, compare.
  task automatic step(input string tag, input logic rst, input logic iv,
                      input logic [3:0] op, input logic [WIDTH-1:0] res,
                      input logic [3:0] fl, input logic ordy, input logic clr);
    logic do_push;
    logic do_pop;
    reset = rst; in_valid = iv; in_opcode = op; in_result = res;
    in_flags = fl; out_ready = ordy; sticky_clear = clr;
    #1;
    if (rst) chk({tag, ".in_ready_in_reset"}, 64'(in_ready), 64'(0));
    do_push = iv && !rst && (q.size() < DEPTH);
    do_pop  = ordy && !rst && (q.size() > 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    if (rst) begin
      q.delete();
      m_ov = 1'b0;
      m_cy = 1'b0;
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back({op, res, fl});
      if (clr) begin
        m_ov = 1'b0;
        m_cy = 1'b0;
      end
      if (do_push && (op == 4'd6 || op == 4'd7)) begin
        if (fl[3]) m_ov = 1'b1;
        if (fl[2]) m_cy = 1'b1;
      end
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    // 1: reset then idle
    step("rst", 1'b1, 1'b0, 4'd0, '0, 4'd0, 1'b0, 1'b0);
    step("idle", 1'b0, 1'b0, 4'd0, '0, 4'd0, 1'b0, 1'b0);
    chk("idle.result_zero", 64'(out_result), 64'(0));

    // 2: single push, one-cycle latency, then pop
    step("t2_push", 1'b0, 1'b1, 4'd0, 32'd5, 4'd0, 1'b0, 1'b0);
    chk("t2.result5", 64'(out_result), 64'(5));
    step("t2_pop", 1'b0, 1'b0, 4'd0, '0, 4'd0, 1'b1, 1'b0);
    chk("t2.empty", 64'(count), 64'(0));

    // 3: fill, overflow attempt dropped, drain in order
    for (int i = 1; i <= 4; i++)
      step("t3_fill", 1'b0, 1'b1, 4'd1, WIDTH'(i), 4'd0, 1'b0, 1'b0);
    chk("t3.full_ready", 64'(in_ready), 64'(0));
    step("t3_drop", 1'b0, 1'b1, 4'd1, 32'd9, 4'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      chk("t3.drain_head", 64'(out_result), 64'(i));
      step("t3_drain", 1'b0, 1'b0, 4'd0, '0, 4'd0, 1'b1, 1'b0);
    end
    chk("t3.drained", 64'(out_valid), 64'(0));
    step("t3_empty_pop", 1'b0, 1'b0, 4'd0, '0, 4'd0, 1'b1, 1'b0);

    // 4: steady-state push+pop at count 2 with pointer wrap
    step("t4_pre", 1'b0, 1'b1, 4'd2, 32'd10, 4'd0, 1'b0, 1'b0);
    step("t4_pre", 1'b0, 1'b1, 4'd2, 32'd11, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("t4.head", 64'(out_result), 64'(10 + i));
      step("t4_stream", 1'b0, 1'b1, 4'd2, WIDTH'(12 + i), 4'd0, 1'b1, 1'b0);
      chk("t4.count2", 64'(count), 64'(2));
    end
    step("t4_flush", 1'b0, 1'b0, 4'd0, '0, 4'd0, 1'b1, 1'b0);
    step("t4_flush", 1'b0, 1'b0, 4'd0, '0, 4'd0, 1'b1, 1'b0);

    // 5: sticky flag filtering and clear-vs-set priority
    step("t5_add", 1'b0, 1'b1, 4'b0110, 32'd1, 4'b1000, 1'b1, 1'b0);
    chk("t5.add_sticky", 64'(sticky_flags), 64'(2'b10));
    step("t5_xor", 1'b0, 1'b1, 4'b0010, 32'd2, 4'b0100, 1'b1, 1'b0);
    chk("t5.xor_sticky", 64'(sticky_flags), 64'(2'b10));
    step("t5_subclr", 1'b0, 1'b1, 4'b0111, 32'd3, 4'b0100, 1'b1, 1'b1);
    chk("t5.sub_clr_sticky", 64'(sticky_flags), 64'(2'b01));
    step("t5_flush", 1'b0, 1'b0, 4'd0, '0, 4'd0, 1'b1, 1'b0);

    // 6: mid-operation reset discards entries
    for (int i = 0; i < 3; i++)
      step("t6_fill", 1'b0, 1'b1, 4'b0110, WIDTH'(100 + i), 4'b1100, 1'b0, 1'b0);
    step("t6_rst", 1'b1, 1'b0, 4'd0, '0, 4'd0, 1'b0, 1'b0);
    chk("t6.count0", 64'(count), 64'(0));
    step("t6_push7", 1'b0, 1'b1, 4'd3, 32'd7, 4'd0, 1'b0, 1'b0);
    chk("t6.head7", 64'(out_result), 64'(7));

    // Random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15))
                                       : 4'($urandom_range(6, 7));
      step("rand", ($urandom_range(0, 60) == 0), 1'($urandom), op, WIDTH'($urandom),
           4'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
